// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with branch/jump/jr selection,
// misaligned-target trap, permanent halt and a saturating retire counter.
//
// Ports:
//   i_clk            clock, all state on rising edge
//   i_reset          synchronous active-high reset
//   i_imem_ready     current fetch complete, PC may advance
//   i_branch/i_zero  conditional branch, taken iff both set
//   i_branch_offset  sign-extended word offset (shifted here)
//   i_jump/i_jump_target   absolute jump
//   i_jump_reg/i_rs_value  register jump (jr)
//   i_halt           permanent stop request
//   i_trap_ack       release a pending trap
//   o_pc             registered program counter
//   o_pc_plus4       o_pc + 4 (combinational)
//   o_state          RUN=00, HALT=01, TRAP=10
//   o_trap           high while in TRAP
//   o_badaddr        last misaligned target
//   o_instr_count    saturating count of retired PC advances
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_imem_ready,
  input  logic        i_branch,
  input  logic        i_zero,
  input  logic [31:0] i_branch_offset,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_jump_reg,
  input  logic [31:0] i_rs_value,
  input  logic        i_halt,
  input  logic        i_trap_ack,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic [1:0]  o_state,
  output logic        o_trap,
  output logic [31:0] o_badaddr,
  output logic [31:0] o_instr_count
);

  typedef enum logic [1:0] {
    StRun  = 2'b00,
    StHalt = 2'b01,
    StTrap = 2'b10
  } state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_badaddr;
  logic [31:0] r_instr_count;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_target;
  logic [31:0] w_candidate;
  logic        w_misaligned;
  logic        w_advance;

  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_branch_target = w_pc_plus4 + {i_branch_offset[29:0], 2'b00};

  // Priority: jr > jump > taken branch > sequential.
  always_comb begin
    w_candidate = w_pc_plus4;
    if (i_jump_reg) begin
      w_candidate = i_rs_value;
    end else if (i_jump) begin
      w_candidate = i_jump_target;
    end else if (i_branch && i_zero) begin
      w_candidate = w_branch_target;
    end
  end

  assign w_misaligned = |w_candidate[1:0];
  // A fetch completes in RUN without a halt request: either retire or trap.
  assign w_advance    = (r_state == StRun) && i_imem_ready && !i_halt;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StRun;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StRun: begin
        if (i_imem_ready) begin
          if (i_halt) begin
            w_state_next = StHalt;
          end else if (w_misaligned) begin
            w_state_next = StTrap;
          end
        end
      end
      StTrap: begin
        if (i_trap_ack) begin
          w_state_next = StRun;
        end
      end
      StHalt:  w_state_next = StHalt;
      default: w_state_next = StRun;
    endcase
  end

  // Outputs
  always_comb begin
    o_trap  = (r_state == StTrap);
    o_state = r_state;
  end

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc          <= RESET_PC;
      r_badaddr     <= 32'd0;
      r_instr_count <= 32'd0;
    end else if (w_advance) begin
      if (w_misaligned) begin
        r_pc      <= TRAP_PC;
        r_badaddr <= w_candidate;
      end else begin
        r_pc <= w_candidate;
        if (r_instr_count != 32'hFFFF_FFFF) begin
          r_instr_count <= r_instr_count + 32'd1;
        end
      end
    end
  end

  assign o_pc          = r_pc;
  assign o_pc_plus4    = w_pc_plus4;
  assign o_badaddr     = r_badaddr;
  assign o_instr_count = r_instr_count;

endmodule
